jtdsp16_do_seq: RTL

Sequencer for the DSP16 `do`/`redo` instruction cache. It takes the `do` command from the instruction decoder, captures the next NI instruction words fetched from ROM, and replays them from its internal 15-entry cache K-1 more times. While replaying, it holds the XAAU program counter and blocks interrupts. It sits between the ROM data bus, the decoder and the XAAU.

---
 rtl/jtdsp16_do_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/jtdsp16_do_seq.sv
// DSP16 do/redo sequencer: captures an NI-word loop body from ROM and replays it K-1 times
// (K times for redo). Redo support is enabled by defining JTDSP16_DO_REDO_EN.
module jtdsp16_do_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        do_start,
  input  logic [10:0] do_data,
  input  logic        ins_fetch,
  input  logic [15:0] rom_dout,
  output logic        up_xcache,
  output logic [15:0] cache_dout,
  output logic        pc_hold,
  output logic        no_int,
  output logic [6:0]  iter_left,
  output logic        do_err
);

  localparam int unsigned DataW = 16;
  localparam int unsigned PtrW  = 4;
  localparam int unsigned IterW = 7;
  localparam int unsigned Depth = 15;

`ifdef JTDSP16_DO_REDO_EN
  localparam bit RedoEn = 1'b1;
`else
  localparam bit RedoEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PtrW-1:0]  ni_q, ni_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [IterW-1:0] iter_q, iter_d;
  logic             cache_valid_q, cache_valid_d;
  logic             do_err_q, do_err_d;
  logic             mem_we_c;
  logic [DataW-1:0] mem [Depth];

  logic [PtrW-1:0]  cmd_ni;
  logic [IterW-1:0] cmd_k;
  logic             body_end_c;

  assign cmd_ni     = do_data[10:7];
  assign cmd_k      = do_data[6:0];
  assign body_end_c = (ptr_q == PtrW'(ni_q - PtrW'(1)));

  // Next-state logic; commands outside IDLE are rejected but never disturb a running loop
  always_comb begin
    state_d       = state_q;
    ni_d          = ni_q;
    ptr_d         = ptr_q;
    iter_d        = iter_q;
    cache_valid_d = cache_valid_q;
    do_err_d      = 1'b0;
    mem_we_c      = 1'b0;

    if (do_start && ((state_q != IDLE) || (cmd_k == '0) ||
                     ((cmd_ni == '0) && !cache_valid_q))) begin
      do_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (do_start && (cmd_k != '0)) begin
          if (cmd_ni != '0) begin
            ni_d          = cmd_ni;
            iter_d        = cmd_k;
            ptr_d         = '0;
            cache_valid_d = 1'b0;
            state_d       = FILL;
          end else if (cache_valid_q) begin
            iter_d  = cmd_k;
            ptr_d   = '0;
            state_d = REPLAY;
          end
        end
      end
      FILL: begin
        if (ins_fetch) begin
          mem_we_c = 1'b1;
          if (body_end_c) begin
            cache_valid_d = 1'b1;
            iter_d        = IterW'(iter_q - IterW'(1));
            ptr_d         = '0;
            state_d       = (iter_q == IterW'(1)) ? IDLE : REPLAY;
          end else begin
            ptr_d = PtrW'(ptr_q + PtrW'(1));
          end
        end
      end
      REPLAY: begin
        if (ins_fetch) begin
          if (body_end_c) begin
            ptr_d  = '0;
            iter_d = IterW'(iter_q - IterW'(1));
            if (iter_q == IterW'(1)) state_d = IDLE;
          end else begin
            ptr_d = PtrW'(ptr_q + PtrW'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Without redo support the cache is never considered reusable
    cache_valid_d = cache_valid_d & RedoEn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ni_q          <= '0;
      ptr_q         <= '0;
      iter_q        <= '0;
      cache_valid_q <= 1'b0;
      do_err_q      <= 1'b0;
    end else if (cen) begin
      state_q       <= state_d;
      ni_q          <= ni_d;
      ptr_q         <= ptr_d;
      iter_q        <= iter_d;
      cache_valid_q <= cache_valid_d;
      do_err_q      <= do_err_d;
    end
  end

  // Cache storage has no reset; contents are only meaningful once cache_valid is set
  always_ff @(posedge clk) begin
    if (cen && mem_we_c) mem[ptr_q] <= rom_dout;
  end

  assign up_xcache  = (state_q == REPLAY);
  assign pc_hold    = (state_q == REPLAY);
  assign no_int     = (state_q != IDLE);
  assign cache_dout = (state_q == REPLAY) ? mem[ptr_q] : '0;
  assign iter_left  = iter_q;
  assign do_err     = do_err_q;

endmodule
